secret_source: RTL and testbench
================================

# secret_source

Upstream stage of the guess game: produces the 6-bit secret numbers the game compares guesses against. A free-running Galois LFSR, optionally perturbed by an entropy input, is sampled on request. A draw never repeats the previously issued number. Each number is delivered through a valid/ready handshake and held stable until the game consumes it.

## Interface

Parameters:
- `LFSR_W`, 16: LFSR width. Fixed polynomial x^16+x^14+x^13+x^11+1, Galois mask 16'hB400.
- `NUM_W`, 6: issued number width; matches the guess width.
- `SEED`, 16'hACE1: reset value; also substituted for any all-zero seed.
- `RETRY_MAX`, 3: number of rejected candidates allowed before the forced fallback.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request a new number; sampled only in IDLE.
- `entropy` in 1: XORed into LFSR bit 0 on each advance.
- `seed_load` in 1: load `seed` into the LFSR this cycle.
- `seed` in 16: seed value.
- `num_out` out NUM_W: issued number; stable while `num_valid` is high.
- `num_valid` out 1: a number is available.
- `num_ready` in 1: consumer accepts `num_out`.
- `busy` out 1: high in DRAW and HOLD.

## Operation

- Reset values:
  - LFSR = SEED, state = IDLE, `num_out` = 0, `num_valid` = 0, `busy` = 0.
  - last-issued register = 0, `last_vld` = 0, retry counter = 0.
- LFSR advances every cycle in every state.
  - Next value = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0), then bit 0 ^= `entropy`.
  - The all-zero state is never held: if the next value computes to 0, load SEED instead.
- `seed_load` has priority over the advance: LFSR <= (`seed` == 0 ? SEED : `seed`). It is legal in any state and does not change the FSM state.
- Candidate = lfsr[NUM_W-1:0], using the LFSR value before that edge's update.
- FSM:
  - IDLE: if `req`, go to DRAW and clear the retry counter.
  - DRAW, each cycle:
    - If `last_vld` and candidate == last-issued, and retry < RETRY_MAX: increment retry, stay in DRAW.
    - Else if a reject with retry == RETRY_MAX: issue candidate ^ 1. This is guaranteed different from last-issued.
    - Else: issue candidate.
    - Issuing means: `num_out` <= value, last-issued <= value, `last_vld` <= 1, `num_valid` <= 1, go to HOLD.
  - HOLD: `num_valid` = 1 and `num_out` is frozen. When `num_ready`, clear `num_valid` next edge and go to IDLE.
- `req` is ignored in DRAW and HOLD; there is no queuing.
- Mid-operation `rst` immediately returns all state to reset values. No number issued before the reset is remembered (`last_vld` = 0).

## Timing

- `req` high at edge n in IDLE gives DRAW at n+1.
- Without a reject, `num_valid` rises after edge n+2: latency 2 cycles.
- Worst case (RETRY_MAX rejects): latency 2+RETRY_MAX cycles.
- Handshake completes on the edge where `num_valid` && `num_ready`. `num_valid` is low the following cycle.
- Minimum spacing between issued numbers is 3 cycles (HOLD → IDLE → DRAW → HOLD).
- `num_ready` is a don't-care outside HOLD.
- `req` and handshake in the same cycle in HOLD: the handshake completes and `req` is ignored. A `req` still high in IDLE the next cycle starts a draw.
- `busy` is registered and equals (state != IDLE).

## Test plan

- Reset check: assert `rst` mid-HOLD → `num_valid`/`busy`/`num_out` = 0 immediately, LFSR = 16'hACE1 after release.
- Seed sequence: `seed_load` with 16'h0001, then 1 idle cycle with `entropy` = 0 → LFSR 16'h0001 then 16'hB400. `seed` = 0 loads 16'hACE1.
- Basic draw, entropy 0:
  - Stimulus: load 16'h0025, pulse `req` on the next cycle.
  - Required response: `num_valid` 2 cycles later; `num_out` equals the low 6 bits of the LFSR sampled in DRAW.
  - `num_out` holds with `num_ready` low for 10 cycles.
- Repeat rejection and fallback:
  - First draw: issue 6'h25 (seed 16'h0025 loaded just before DRAW).
  - Second draw: hold `seed_load` high with 16'h0025 every cycle so the candidate stays 6'h25.
  - Required response: 3 rejects, then `num_out` = 6'h24 at latency 5.
- Handshake edge cases:
  - `num_ready` held high continuously with `req` high → a new number every 3 cycles.
  - `req` pulses during DRAW/HOLD → ignored.
- Randomized: 1000 draws with random `entropy`/`num_ready` → no two consecutive issued numbers are equal, and the LFSR never reads 0.

Source files
------------

// File: rtl/secret_source_if.sv
// Handshake bundle between the secret source and the guess game.
// The source drives the number and status; the game drives request and ready.
interface secret_source_if #(
  parameter int NUM_W = 6
);
  logic             req;
  logic [NUM_W-1:0] num_out;
  logic             num_valid;
  logic             num_ready;
  logic             busy;

  modport master (
    input  req,
    input  num_ready,
    output num_out,
    output num_valid,
    output busy
  );

  modport slave (
    output req,
    output num_ready,
    input  num_out,
    input  num_valid,
    input  busy
  );
endinterface

// File: rtl/secret_source.sv
// Secret number source: free-running Galois LFSR sampled on request, with
// repeat rejection against the previously issued number and a valid/ready hold.
module secret_source #(
  parameter int                LFSR_W    = 16,
  parameter int                NUM_W     = 6,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                RETRY_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entropy,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  secret_source_if.master   bus
);

  localparam logic [LFSR_W-1:0] POLY_MASK = LFSR_W'(16'hB400);
  localparam int                RETRY_W   = $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [LFSR_W-1:0]  lfsr_reg, lfsr_next, lfsr_shift, lfsr_adv;
  logic [NUM_W-1:0]   num_reg, num_next;
  logic [NUM_W-1:0]   last_reg, last_next;
  logic               last_vld_reg, last_vld_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               valid_reg, busy_reg;
  logic [NUM_W-1:0]   cand;
  logic               reject, retry_left;

  // Galois step: shift right and fold the output bit back through the taps.
  genvar gi;
  generate
    for (gi = 0; gi < LFSR_W - 1; gi++) begin : g_shift
      assign lfsr_shift[gi] = lfsr_reg[gi+1] ^ (POLY_MASK[gi] & lfsr_reg[0]);
    end
  endgenerate
  assign lfsr_shift[LFSR_W-1] = POLY_MASK[LFSR_W-1] & lfsr_reg[0];

  always_comb begin
    lfsr_adv    = {lfsr_shift[LFSR_W-1:1], lfsr_shift[0] ^ entropy};
    lfsr_next   = (lfsr_adv == '0) ? SEED : lfsr_adv;
    if (seed_load) begin
      lfsr_next = (seed == '0) ? SEED : seed;
    end
  end

  assign cand       = lfsr_reg[NUM_W-1:0];
  assign reject     = last_vld_reg && (cand == last_reg);
  assign retry_left = (retry_reg < RETRY_W'(RETRY_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      lfsr_reg     <= SEED;
      num_reg      <= '0;
      last_reg     <= '0;
      last_vld_reg <= 1'b0;
      retry_reg    <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      num_reg      <= num_next;
      last_reg     <= last_next;
      last_vld_reg <= last_vld_next;
      retry_reg    <= retry_next;
      valid_reg    <= (state_next == HOLD);
      busy_reg     <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req) state_next = DRAW;
      DRAW:    if (!(reject && retry_left)) state_next = HOLD;
      HOLD:    if (bus.num_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Once retries are exhausted, flipping bit 0 guarantees a fresh number.
  always_comb begin
    num_next      = num_reg;
    last_next     = last_reg;
    last_vld_next = last_vld_reg;
    retry_next    = retry_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) retry_next = '0;
      end
      DRAW: begin
        if (reject && retry_left) begin
          retry_next = retry_reg + RETRY_W'(1);
        end else begin
          num_next      = reject ? (cand ^ NUM_W'(1)) : cand;
          last_next     = num_next;
          last_vld_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.num_out   = num_reg;
  assign bus.num_valid = valid_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_secret_source.sv
// Randomized and directed bench for secret_source against a cycle-level
// reference model of the draw/hold protocol and the LFSR arithmetic.
module tb_secret_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        entropy;
  logic        seed_load;
  logic [15:0] seed;

  secret_source_if #(.NUM_W(6)) bus ();

  secret_source dut (
    .clk       (clk),
    .rst       (rst),
    .entropy   (entropy),
    .seed_load (seed_load),
    .seed      (seed),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int issues = 0;

  // reference model state
  logic [15:0] m_lfsr;
  int          m_mode;     // 0 idle, 1 drawing, 2 holding
  int          m_retry;
  logic [5:0]  m_last;
  bit          m_last_vld;
  logic [5:0]  m_num;
  bit          m_issued;
  bit          have_prev;
  logic [5:0]  prev_issue;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic e);
    logic [15:0] n;
    n = v / 2;
    if (v % 2 == 1) n = n ^ 16'hB400;
    n = n ^ {15'd0, e};
    if (n == 16'd0) n = 16'hACE1;
    return n;
  endfunction

  task automatic model_reset();
    m_lfsr     = 16'hACE1;
    m_mode     = 0;
    m_retry    = 0;
    m_last     = '0;
    m_last_vld = 0;
    m_num      = '0;
    m_issued   = 0;
    have_prev  = 0;
  endtask

  task automatic model_edge();
    logic [5:0] cand;
    bit         same;
    cand     = m_lfsr[5:0];
    same     = m_last_vld && (cand == m_last);
    m_issued = 0;
    case (m_mode)
      0: if (bus.req) begin m_mode = 1; m_retry = 0; end
      1: begin
        if (same && m_retry < 3) begin
          m_retry++;
        end else begin
          m_num      = same ? (cand ^ 6'h01) : cand;
          m_last     = m_num;
          m_last_vld = 1;
          m_mode     = 2;
          m_issued   = 1;
        end
      end
      default: if (bus.num_ready) m_mode = 0;
    endcase
    m_lfsr = seed_load ? ((seed == 16'd0) ? 16'hACE1 : seed) : lfsr_step(m_lfsr, entropy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    check_eq("valid", 32'(bus.num_valid), 32'(m_mode == 2));
    check_eq("busy", 32'(bus.busy), 32'(m_mode != 0));
    check_eq("num_out", 32'(bus.num_out), 32'(m_num));
    check_eq("lfsr", 32'(dut.lfsr_reg), 32'(m_lfsr));
    check_eq("lfsr_nonzero", 32'(dut.lfsr_reg != 16'd0), 32'd1);
    if (m_issued) begin
      issues++;
      if (have_prev) check_eq("no_repeat", 32'(bus.num_out != prev_issue), 32'd1);
      $display("draw %0d: num=%02h rejects=%0d cycle=%0d", issues, bus.num_out, m_retry, cycle);
      prev_issue = bus.num_out;
      have_prev  = 1;
    end
  endtask

  initial begin
    int lat;
    int prev_cyc;
    int b2b_issues;

    rst = 1'b1; entropy = 1'b0; seed_load = 1'b0; seed = '0;
    bus.req = 1'b0; bus.num_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_valid", 32'(bus.num_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_num", 32'(bus.num_out), 32'd0);
    check_eq("rst_lfsr", 32'(dut.lfsr_reg), 32'hACE1);
    rst = 1'b0;

    // seed loading and the zero-seed substitution
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    check_eq("seed_0001", 32'(dut.lfsr_reg), 32'h0001);
    seed_load = 1'b0;
    tick();
    check_eq("seed_step", 32'(dut.lfsr_reg), 32'hB400);
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    check_eq("seed_zero", 32'(dut.lfsr_reg), 32'hACE1);
    seed_load = 1'b0;

    // basic draw: 0x0025 advances to 0xB412 before it is sampled in DRAW
    seed_load = 1'b1; seed = 16'h0025;
    tick();
    seed_load = 1'b0; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    check_eq("basic_latency2", 32'(bus.num_valid), 32'd1);
    check_eq("basic_num", 32'(bus.num_out), 32'h12);
    repeat (10) tick();
    check_eq("basic_hold", 32'(bus.num_out), 32'h12);
    bus.num_ready = 1'b1;
    tick();
    bus.num_ready = 1'b0;
    check_eq("basic_done", 32'(bus.num_valid), 32'd0);

    // first draw issues 0x25, second draw is pinned to 0x25 and must fall back
    seed_load = 1'b1; seed = 16'h0025; bus.req = 1'b1;
    tick();
    seed_load = 1'b0; bus.req = 1'b0;
    tick();
    check_eq("rej_first", 32'(bus.num_out), 32'h25);
    bus.num_ready = 1'b1;
    tick();
    bus.num_ready = 1'b0;
    seed_load = 1'b1; seed = 16'h0025; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    lat = 1;
    while (!bus.num_valid && lat < 12) begin
      tick();
      lat++;
    end
    check_eq("rej_latency", 32'(lat), 32'd5);
    check_eq("rej_fallback", 32'(bus.num_out), 32'h24);
    seed_load = 1'b0;

    // asynchronous reset in the middle of HOLD
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.num_valid), 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_num", 32'(bus.num_out), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("arst_lfsr", 32'(dut.lfsr_reg), 32'hACE1);

    // back-to-back: ready and req held high
    bus.req = 1'b1; bus.num_ready = 1'b1;
    prev_cyc = cycle - 1;
    b2b_issues = 0;
    repeat (30) begin
      tick();
      if (m_issued) begin
        check_eq("b2b_spacing", 32'(cycle - prev_cyc), 32'(3 + m_retry));
        prev_cyc = cycle;
        b2b_issues++;
      end
    end
    check_eq("b2b_some", 32'(b2b_issues >= 7), 32'd1);

    // req during DRAW/HOLD is ignored; completing the handshake returns to IDLE
    bus.num_ready = 1'b0;
    lat = 0;
    while (!(bus.num_valid && bus.busy && m_mode == 2) && lat < 10) begin
      tick();
      lat++;
    end
    bus.req = 1'b1;
    repeat (3) tick();
    check_eq("req_ignored_hold", 32'(bus.num_valid), 32'd1);
    bus.req = 1'b0; bus.num_ready = 1'b1;
    tick();
    bus.num_ready = 1'b0;
    tick();
    check_eq("idle_after_ack", 32'(bus.busy), 32'd0);

    // randomized run
    issues = 0;
    lat = 0;
    while (issues < 1000 && lat < 30000) begin
      entropy       = 1'($urandom % 2);
      bus.req       = 1'(($urandom % 4) != 0);
      bus.num_ready = 1'($urandom % 2);
      seed_load     = 1'(($urandom % 32) == 0);
      seed          = (($urandom % 8) == 0) ? 16'd0 : 16'($urandom);
      tick();
      lat++;
    end
    check_eq("rand_completed", 32'(issues >= 1000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
